// File: rtl/urp_tx_tlp_arbiter_if.sv
// Requester, TX-layer and credit-return signal bundle for urp_tx_tlp_arbiter.
// The slave modport is the arbiter's view; master is the requester/TX-layer side.
interface urp_tx_tlp_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CRED_W  = 8
);
  logic [NUM_REQ-1:0]     req_valid_i;
  logic [NUM_REQ*80-1:0]  req_desc_i;
  logic [NUM_REQ*128-1:0] req_payload_i;
  logic [NUM_REQ-1:0]     req_ready_o;
  logic [127:0]           payload_o;
  logic [31:0]            addr_o;
  logic [2:0]             header_fmt_o;
  logic [4:0]             header_type_o;
  logic [2:0]             header_tc_o;
  logic [15:0]            header_requestID_o;
  logic [15:0]            header_completID_o;
  logic                   tlp_valid_o;
  logic                   tlp_ready_i;
  logic                   fc_update_valid_i;
  logic [1:0]             fc_class_i;
  logic [CRED_W-1:0]      fc_credits_i;
  logic [CRED_W-1:0]      cred_p_o;
  logic [CRED_W-1:0]      cred_np_o;
  logic [CRED_W-1:0]      cred_cpl_o;

  modport slave (
    input  req_valid_i, req_desc_i, req_payload_i, tlp_ready_i,
           fc_update_valid_i, fc_class_i, fc_credits_i,
    output req_ready_o, payload_o, addr_o, header_fmt_o, header_type_o,
           header_tc_o, header_requestID_o, header_completID_o, tlp_valid_o,
           cred_p_o, cred_np_o, cred_cpl_o
  );

  modport master (
    output req_valid_i, req_desc_i, req_payload_i, tlp_ready_i,
           fc_update_valid_i, fc_class_i, fc_credits_i,
    input  req_ready_o, payload_o, addr_o, header_fmt_o, header_type_o,
           header_tc_o, header_requestID_o, header_completID_o, tlp_valid_o,
           cred_p_o, cred_np_o, cred_cpl_o
  );
endinterface

// File: rtl/urp_tx_tlp_arbiter.sv
// Credit-gated round-robin TLP arbiter (strict priority with URP_TX_ARB_STRICT_PRIO_EN).
// Latency: accept pulse in the IDLE cycle, tlp_valid_o one cycle later; one TLP per 2 cycles.
// Backpressure: TLP held stable while tlp_ready_i is low; requests wait with no credit.
module urp_tx_tlp_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int CRED_W        = 8,
  parameter int INIT_P_CRED   = 16,
  parameter int INIT_NP_CRED  = 16,
  parameter int INIT_CPL_CRED = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  urp_tx_tlp_arbiter_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] CLS_P   = 2'd0;
  localparam logic [1:0] CLS_NP  = 2'd1;
  localparam logic [1:0] CLS_CPL = 2'd2;
  localparam logic [CRED_W:0] LIM_P   = (CRED_W+1)'(INIT_P_CRED);
  localparam logic [CRED_W:0] LIM_NP  = (CRED_W+1)'(INIT_NP_CRED);
  localparam logic [CRED_W:0] LIM_CPL = (CRED_W+1)'(INIT_CPL_CRED);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [GW-1:0]      grant;
  logic               found;
  logic               take;
  logic [1:0]         cls [NUM_REQ];
  logic [1:0]         gcls;
  logic [NUM_REQ-1:0] elig;
  logic [CRED_W-1:0]  cred_p, cred_np, cred_cpl;
  logic               ret_p, ret_np, ret_cpl;

  function automatic logic [1:0] tlp_class(input logic [4:0] typ, input logic fmt1);
    if (typ == 5'b01010)
      return CLS_CPL;
    else if (typ == 5'b00000 && fmt1)
      return CLS_P;
    else
      return CLS_NP;
  endfunction

  // Sum is one bit wider so a large return cannot wrap before clamping.
  function automatic logic [CRED_W-1:0] cred_next(input logic [CRED_W-1:0] cur,
                                                  input logic              use_c,
                                                  input logic              ret_c,
                                                  input logic [CRED_W-1:0] amt,
                                                  input logic [CRED_W:0]   lim);
    logic [CRED_W:0] sum;
    sum = {1'b0, cur} - {{CRED_W{1'b0}}, use_c} + (ret_c ? {1'b0, amt} : '0);
    if (sum > lim)
      return lim[CRED_W-1:0];
    return sum[CRED_W-1:0];
  endfunction

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cls[k] = tlp_class(bus.req_desc_i[80*k+35 +: 5], bus.req_desc_i[80*k+33]);
      case (cls[k])
        CLS_P:   elig[k] = bus.req_valid_i[k] && (cred_p != '0);
        CLS_CPL: elig[k] = bus.req_valid_i[k] && (cred_cpl != '0);
        default: elig[k] = bus.req_valid_i[k] && (cred_np != '0);
      endcase
    end
  end

`ifdef URP_TX_ARB_STRICT_PRIO_EN
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        grant = GW'(i);
      end
    end
  end
`else
  logic [GW-1:0] last_grant;
  logic [GW-1:0] rr_sel;

  always_comb begin
    found  = 1'b0;
    grant  = '0;
    rr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sel = GW'((int'(last_grant) + 1 + i) % NUM_REQ);
      if (!found && elig[rr_sel]) begin
        found = 1'b1;
        grant = rr_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= GW'(NUM_REQ-1);
    else if (state == IDLE && found)
      last_grant <= grant;
  end
`endif

  assign take = (state == IDLE) && found;
  assign gcls = cls[grant];

  always_comb begin
    bus.req_ready_o = '0;
    if (take)
      bus.req_ready_o[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      bus.tlp_valid_o        <= 1'b0;
      bus.payload_o          <= '0;
      bus.addr_o             <= '0;
      bus.header_fmt_o       <= '0;
      bus.header_type_o      <= '0;
      bus.header_tc_o        <= '0;
      bus.header_requestID_o <= '0;
      bus.header_completID_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state                  <= SEND;
            bus.tlp_valid_o        <= 1'b1;
            bus.payload_o          <= bus.req_payload_i[128*int'(grant) +: 128];
            bus.addr_o             <= bus.req_desc_i[80*int'(grant)    +: 32];
            bus.header_fmt_o       <= bus.req_desc_i[80*int'(grant)+32 +: 3];
            bus.header_type_o      <= bus.req_desc_i[80*int'(grant)+35 +: 5];
            bus.header_tc_o        <= bus.req_desc_i[80*int'(grant)+40 +: 3];
            bus.header_requestID_o <= bus.req_desc_i[80*int'(grant)+43 +: 16];
            bus.header_completID_o <= bus.req_desc_i[80*int'(grant)+59 +: 16];
          end
        end
        SEND: begin
          if (bus.tlp_ready_i) begin
            state           <= IDLE;
            bus.tlp_valid_o <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ret_p   = bus.fc_update_valid_i && (bus.fc_class_i == CLS_P);
  assign ret_np  = bus.fc_update_valid_i && (bus.fc_class_i == CLS_NP);
  assign ret_cpl = bus.fc_update_valid_i && (bus.fc_class_i == CLS_CPL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cred_p   <= CRED_W'(INIT_P_CRED);
      cred_np  <= CRED_W'(INIT_NP_CRED);
      cred_cpl <= CRED_W'(INIT_CPL_CRED);
    end else begin
      cred_p   <= cred_next(cred_p,   take && gcls == CLS_P,   ret_p,   bus.fc_credits_i, LIM_P);
      cred_np  <= cred_next(cred_np,  take && gcls == CLS_NP,  ret_np,  bus.fc_credits_i, LIM_NP);
      cred_cpl <= cred_next(cred_cpl, take && gcls == CLS_CPL, ret_cpl, bus.fc_credits_i, LIM_CPL);
    end
  end

  assign bus.cred_p_o   = cred_p;
  assign bus.cred_np_o  = cred_np;
  assign bus.cred_cpl_o = cred_cpl;
endmodule

// File: tb/tb_urp_tx_tlp_arbiter.sv
// Bench for urp_tx_tlp_arbiter: requester queues, scoreboard of expected TLPs, vector tables.
`timescale 1ns/1ps
module tb_urp_tx_tlp_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  urp_tx_tlp_arbiter_if #(.NUM_REQ(NREQ), .CRED_W(8)) bus();

  urp_tx_tlp_arbiter #(
    .NUM_REQ(NREQ), .CRED_W(8),
    .INIT_P_CRED(16), .INIT_NP_CRED(16), .INIT_CPL_CRED(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed { logic [79:0] d; logic [127:0] p; } item_t;
  typedef struct { int g; logic [79:0] d; logic [127:0] p; } exp_t;
  typedef struct { int k; logic [2:0] f; logic [4:0] t; int ep; int enp; int ecpl; } dec_t;
  typedef struct { logic [1:0] c; logic [7:0] n; int ep; int enp; int ecpl; } fcv_t;

  item_t rq [NREQ][$];
  exp_t  sb [$];
  int    pulse_cyc [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  logic  pending = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [79:0] mkdesc(input logic [31:0] a, input logic [2:0] f,
                                         input logic [4:0] t, input logic [2:0] tc);
    return {5'h15, {8'hC5, a[7:0]}, {8'hA3, a[15:8]}, tc, t, f, a};
  endfunction

  function automatic logic [127:0] mkpl(input logic [31:0] a);
    return {a, ~a, a + 32'd1, a ^ 32'hA5A5A5A5};
  endfunction

  function automatic logic [74:0] exp_hdr(input logic [79:0] d);
    return {d[31:0], d[34:32], d[39:35], d[42:40], d[58:43], d[74:59]};
  endfunction

  task automatic push(input int k, input int g, input logic [79:0] d);
    item_t it;
    exp_t  e;
    it.d = d;
    it.p = mkpl(d[31:0]);
    rq[k].push_back(it);
    e.g = g;
    e.d = d;
    e.p = it.p;
    sb.push_back(e);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_all();
    for (int k = 0; k < NREQ; k++) rq[k].delete();
    sb.delete();
    pulse_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm, input int max);
    int n;
    n = 0;
    while ((sb.size() != 0 || pending) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nm, sb.size(), 0);
  endtask

  task automatic wait_valid(input string nm, input int max);
    int n;
    n = 0;
    while (bus.tlp_valid_o !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nm, bus.tlp_valid_o, 1);
  endtask

  task automatic fc_pulse(input logic [1:0] c, input logic [7:0] n);
    @(posedge clk);
    #1;
    bus.fc_update_valid_i = 1'b1;
    bus.fc_class_i        = c;
    bus.fc_credits_i      = n;
    @(posedge clk);
    #1;
    bus.fc_update_valid_i = 1'b0;
  endtask

  task automatic chk_creds(input string nm, input int p, input int np, input int cpl);
    chk({nm, "_p"},   bus.cred_p_o,   p);
    chk({nm, "_np"},  bus.cred_np_o,  np);
    chk({nm, "_cpl"}, bus.cred_cpl_o, cpl);
  endtask

  // Requester model: present the head of each queue, advance it after its accept pulse.
  initial begin
    logic [NREQ-1:0] acc;
    bus.req_valid_i   = '0;
    bus.req_desc_i    = '0;
    bus.req_payload_i = '0;
    forever begin
      @(negedge clk);
      acc = rst_n ? bus.req_ready_o : '0;
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        if (rq[k].size() > 0) begin
          bus.req_valid_i[k]              = 1'b1;
          bus.req_desc_i[80*k +: 80]      = rq[k][0].d;
          bus.req_payload_i[128*k +: 128] = rq[k][0].p;
        end else begin
          bus.req_valid_i[k] = 1'b0;
        end
      end
    end
  end

  // Output monitor: grant order, accept-to-valid latency, TLP contents.
  initial begin
    logic pulse_prev;
    pulse_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending    = 1'b0;
        pulse_prev = 1'b0;
      end else begin
        if (pulse_prev) chk("accept_to_valid", bus.tlp_valid_o, 1);
        pulse_prev = 1'b0;
        if (bus.req_ready_o != '0) begin
          if (pending || sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_grant: got ready=%b, expected none", bus.req_ready_o);
          end else begin
            chk("grant", bus.req_ready_o, 1 << sb[0].g);
            pending    = 1'b1;
            pulse_prev = 1'b1;
            pulse_cyc.push_back(cyc);
          end
        end
        if (bus.tlp_valid_o && bus.tlp_ready_i) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_tlp: got addr=%0h, expected no TLP", bus.addr_o);
          end else begin
            chk("tlp_hdr", {bus.addr_o, bus.header_fmt_o, bus.header_type_o, bus.header_tc_o,
                            bus.header_requestID_o, bus.header_completID_o}, exp_hdr(sb[0].d));
            chk("tlp_payload", bus.payload_o, sb[0].p);
            void'(sb.pop_front());
          end
          pending = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_t dv [9];
    fcv_t fv [7];
    logic [127:0] pl;
    int n;

    dv[0] = '{0, 3'b010, 5'b00000, 15, 16, 16};
    dv[1] = '{1, 3'b011, 5'b00000, 14, 16, 16};
    dv[2] = '{2, 3'b000, 5'b00000, 14, 15, 16};
    dv[3] = '{3, 3'b001, 5'b00000, 14, 14, 16};
    dv[4] = '{0, 3'b010, 5'b01010, 14, 14, 15};
    dv[5] = '{1, 3'b000, 5'b01010, 14, 14, 14};
    dv[6] = '{2, 3'b010, 5'b00100, 14, 13, 14};
    dv[7] = '{3, 3'b110, 5'b00000, 13, 13, 14};
    dv[8] = '{0, 3'b010, 5'b01011, 13, 12, 14};

    fv[0] = '{2'd2, 8'd7,   0,  9, 10};
    fv[1] = '{2'd2, 8'd40,  0,  9, 16};
    fv[2] = '{2'd3, 8'd5,   0,  9, 16};
    fv[3] = '{2'd0, 8'd255, 16, 9, 16};
    fv[4] = '{2'd1, 8'd3,   16, 12, 16};
    fv[5] = '{2'd1, 8'd0,   16, 12, 16};
    fv[6] = '{2'd1, 8'd4,   16, 16, 16};

    bus.tlp_ready_i       = 1'b1;
    bus.fc_update_valid_i = 1'b0;
    bus.fc_class_i        = '0;
    bus.fc_credits_i      = '0;
    #2;
    do_reset();

    @(negedge clk);
    chk("rst_tlp_valid", bus.tlp_valid_o, 0);
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_hdr", {bus.addr_o, bus.header_fmt_o, bus.header_type_o, bus.header_tc_o,
                    bus.header_requestID_o, bus.header_completID_o}, 0);
    chk("rst_payload", bus.payload_o, 0);
    chk_creds("rst_cred", 16, 16, 16);

    // Single MWr from requester 0.
    sync();
    push(0, 0, mkdesc(32'h1000, 3'b010, 5'b00000, 3'd1));
    wait_drain("mwr_drain", 20);
    chk_creds("mwr_cred", 15, 16, 16);

    // Four NP readers, continuously ready.
    do_reset();
    sync();
    push(0, 0, mkdesc(32'h2000, 3'b000, 5'b00000, 3'd0));
    push(1, 1, mkdesc(32'h2100, 3'b000, 5'b00000, 3'd2));
    push(2, 2, mkdesc(32'h2200, 3'b000, 5'b00000, 3'd3));
    push(3, 3, mkdesc(32'h2300, 3'b000, 5'b00000, 3'd4));
    push(0, 0, mkdesc(32'h2400, 3'b000, 5'b00000, 3'd5));
    wait_drain("rr_drain", 40);
    chk("rr_grant_count", pulse_cyc.size(), 5);
    for (int i = 1; i < 5 && i < pulse_cyc.size(); i++)
      chk("rr_spacing", pulse_cyc[i] - pulse_cyc[i-1], 2);
    chk_creds("rr_cred", 16, 11, 16);

    // Transaction layer stalls for 5 cycles.
    @(posedge clk);
    #1;
    bus.tlp_ready_i = 1'b0;
    sync();
    push(2, 2, mkdesc(32'h4000, 3'b000, 5'b00000, 3'd6));
    pl = mkpl(32'h4000);
    wait_valid("stall_valid_seen", 20);
    sync();
    push(3, 3, mkdesc(32'h4100, 3'b000, 5'b00000, 3'd7));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.tlp_valid_o, 1);
      chk("stall_addr", bus.addr_o, 32'h4000);
      chk("stall_payload", bus.payload_o, pl);
      chk("stall_no_ready", bus.req_ready_o, 0);
    end
    @(posedge clk);
    #1;
    bus.tlp_ready_i = 1'b1;
    wait_drain("stall_drain", 30);
    chk("stall_cred_np", bus.cred_np_o, 9);

    // Posted credit exhaustion on requester 1, then a one-credit return.
    sync();
    for (int i = 0; i < 17; i++)
      push(1, 1, mkdesc(32'h5000 + 32'(i*4), 3'b010, 5'b00000, 3'(i)));
    n = 0;
    while ((sb.size() != 1 || pending) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("p_sixteen_sent", sb.size(), 1);
    repeat (6) @(negedge clk);
    chk("p_held_ready", bus.req_ready_o, 0);
    chk("p_held_valid", bus.tlp_valid_o, 0);
    chk("p_held_cred", bus.cred_p_o, 0);
    chk("p_held_count", sb.size(), 1);
    fc_pulse(2'd0, 8'd1);
    wait_drain("p_return_drain", 20);
    chk("p_after_return", bus.cred_p_o, 0);

    // Completion credits down to 1, then consume and return 3 in the same cycle.
    sync();
    for (int i = 0; i < 15; i++)
      push(2, 2, mkdesc(32'h6000 + 32'(i*4), 3'b010, 5'b01010, 3'd0));
    wait_drain("cpl_drain", 100);
    chk("cpl_one", bus.cred_cpl_o, 1);
    sync();
    push(2, 2, mkdesc(32'h6100, 3'b010, 5'b01010, 3'd1));
    n = 0;
    while (bus.req_ready_o[2] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cpl_pulse_seen", bus.req_ready_o[2], 1);
    bus.fc_update_valid_i = 1'b1;
    bus.fc_class_i        = 2'd2;
    bus.fc_credits_i      = 8'd3;
    @(posedge clk);
    #1;
    bus.fc_update_valid_i = 1'b0;
    @(negedge clk);
    chk("cpl_consume_and_return", bus.cred_cpl_o, 3);
    wait_drain("cpl_last_drain", 20);

    // Credit return vectors.
    for (int i = 0; i < 7; i++) begin
      fc_pulse(fv[i].c, fv[i].n);
      @(negedge clk);
      chk_creds($sformatf("fc%0d", i), fv[i].ep, fv[i].enp, fv[i].ecpl);
    end

    // Class decode vectors, one TLP each.
    for (int i = 0; i < 9; i++) begin
      sync();
      push(dv[i].k, dv[i].k, mkdesc(32'h7000 + 32'(i*16), dv[i].f, dv[i].t, 3'(i)));
      wait_drain($sformatf("dec%0d_drain", i), 20);
      chk_creds($sformatf("dec%0d", i), dv[i].ep, dv[i].enp, dv[i].ecpl);
    end

    // Reset while a TLP is held.
    @(posedge clk);
    #1;
    bus.tlp_ready_i = 1'b0;
    sync();
    push(1, 1, mkdesc(32'h8000, 3'b010, 5'b00000, 3'd2));
    wait_valid("mid_valid_seen", 20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_all();
    #1;
    chk("mid_rst_valid_async", bus.tlp_valid_o, 0);
    chk("mid_rst_addr_async", bus.addr_o, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    bus.tlp_ready_i = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_creds("mid_rst_cred", 16, 16, 16);
    sync();
    push(0, 0, mkdesc(32'h9000, 3'b000, 5'b00000, 3'd0));
    push(3, 3, mkdesc(32'h9300, 3'b000, 5'b00000, 3'd3));
    wait_drain("post_rst_drain", 30);
    chk_creds("post_rst_cred", 16, 14, 16);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/urp_tx_tlp_arbiter.md
Name: urp_tx_tlp_arbiter

Overview:
Shares the single TX transaction-layer TLP input between NUM_REQ requesters, such as DMA, config and completion engines. Gates each request on per-class flow-control credits: posted, non-posted and completion. Credits are replenished by UpdateFC information decoded from received DLLPs. The block sits directly in front of the TX transaction layer and drives its header/payload inputs with a valid/ready handshake.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CRED_W, 8, credit counter width
INIT_P_CRED, 16, posted credits after reset (also the saturation ceiling)
INIT_NP_CRED, 16, non-posted credits after reset (also the saturation ceiling)
INIT_CPL_CRED, 16, completion credits after reset (also the saturation ceiling)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester descriptor valid
req_desc_i  in  NUM_REQ*80  packed descriptors; slice k = [80k+79:80k]
req_payload_i  in  NUM_REQ*128  packed payloads
req_ready_o  out  NUM_REQ  one-cycle accept pulse per requester
payload_o  out  128  payload to transaction layer
addr_o  out  32  address
header_fmt_o  out  3  fmt
header_type_o  out  5  type
header_tc_o  out  3  traffic class
header_requestID_o  out  16  requester ID
header_completID_o  out  16  completer ID
tlp_valid_o  out  1  TLP valid to transaction layer
tlp_ready_i  in  1  transaction layer ready
fc_update_valid_i  in  1  credit return strobe
fc_class_i  in  2  returned class: 0=P, 1=NP, 2=CPL, 3=ignored
fc_credits_i  in  CRED_W  credits returned
cred_p_o / cred_np_o / cred_cpl_o  out  CRED_W each  current credit counts

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Descriptor fields:
  - [31:0] addr, [34:32] fmt, [39:35] type, [42:40] tc
  - [58:43] requestID, [74:59] completID, [79:75] reserved (ignored)
- Class decode:
  - CPL if type==5'b01010.
  - P if type==5'b00000 and fmt[1]==1.
  - Otherwise NP.
  - Each TLP consumes exactly 1 credit of its class.
- Eligible requester k: req_valid_i[k]==1 and the credit counter of its class is non-zero.
- FSM states: IDLE, SEND.
  - IDLE → SEND when at least one requester is eligible. In that cycle:
    - pick grant g by round-robin, starting at (last_grant+1) mod NUM_REQ;
    - register descriptor and payload g into the output registers;
    - pulse req_ready_o[g]=1;
    - decrement g's class credit;
    - set last_grant=g.
  - SEND: tlp_valid_o=1. Outputs are held stable until tlp_valid_o & tlp_ready_i, then → IDLE.
  - Throughput is one TLP per 2 cycles minimum. Latency from accept pulse to tlp_valid_o is 1 cycle.
- Requesters must hold descriptors stable while valid; they may drop valid at any time before their accept pulse.
- Credit update:
  - next = cur − consume + (fc_update_valid_i && class match ? fc_credits_i : 0).
  - Compute at CRED_W+1 bits, then saturate to the INIT ceiling.
  - Simultaneous consume and return on the same class is applied in one cycle. Example: 1 − 1 + 3 = 3.
  - A counter never underflows, since consumption requires non-zero credit.
- Reset values:
  - state IDLE, tlp_valid_o=0, req_ready_o=0;
  - all header/payload outputs 0;
  - last_grant=NUM_REQ−1, so requester 0 wins first;
  - credits = INIT values.
- Reset mid-SEND discards the held TLP. Its consumed credit is restored to INIT by reset.
- fc_class_i==3 is ignored.

Optional Feature:
URP_TX_ARB_STRICT_PRIO_EN:
- Defined: fixed priority, lowest eligible index wins; last_grant is unused.
- Undefined: round-robin as above.
- Credit gating and all handshakes are identical in both modes.

Test Plan:
1. Reset, then req_valid_i=4'b0001 with an MWr descriptor (fmt=3'b010, type=0, addr=32'h1000) → req_ready_o[0] pulse at cycle 1; tlp_valid_o=1 with addr_o=32'h1000; cred_p_o 16→15.
2. All four requesters valid with NP reads and tlp_ready_i=1 continuously → grants 0,1,2,3,0 in order, one TLP every 2 cycles; cred_np_o decrements by 1 per grant.
3. INIT_P_CRED=2, requester 1 issues 3 MWr → two TLPs sent, third held (no ready pulse, cred_p_o=0). fc_update P credits=1 → third is sent.
4. tlp_ready_i=0 for 5 cycles during SEND → tlp_valid_o and all outputs stable for 5 cycles; no further req_ready_o pulses.
5. cred_cpl_o=1 while a CPL grant coincides with fc_update CPL=3 → cred_cpl_o=3 next cycle. Returning 40 at cred_cpl_o=10 → saturates at 16.
6. rst_n asserted low mid-SEND → tlp_valid_o drops immediately (asynchronous); after release, credits=16/16/16 and requester 0 is granted first.
